// File: rtl/cp0_exc.sv
// CP0 register file and precise-exception controller for the MEM stage of the MIPS core.
// Picks the highest-priority pending exception, updates CP0 state and redirects fetch.
module cp0_exc #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter logic [31:0] STATUS_RST = 32'h00400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        exc_valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        sys_i,
    input  logic        bp_i,
    input  logic        ov_i,
    input  logic        adel_d_i,
    input  logic        ades_i,
    input  logic        eret_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic [4:0]  exccode_o,
    output logic        timer_int_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_BD  = 31;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_q, timer_d;
    logic        tick_q, tick_d;

    logic        irq_pending;
    logic        exc_hit;
    logic [4:0]  exc_code;
    logic        bad_from_pc;
    logic        bad_from_addr;
    logic        exc_take;
    logic        eret_take;
    logic        wr_en;

    // Hardware interrupt 5 shares IP7 with the timer, so its pin is never sampled.
    logic int5_unused;
    assign int5_unused = int_i[5];

    assign irq_pending = status_q[ST_IE] && !status_q[ST_EXL] &&
                         (|(cause_q[15:8] & status_q[15:8]));

    always_comb begin
        exc_hit       = 1'b0;
        exc_code      = EXC_INT;
        bad_from_pc   = 1'b0;
        bad_from_addr = 1'b0;
        if (irq_pending) begin
            exc_hit  = 1'b1;
            exc_code = EXC_INT;
        end else if (adel_if_i) begin
            exc_hit     = 1'b1;
            exc_code    = EXC_ADEL;
            bad_from_pc = 1'b1;
        end else if (ri_i) begin
            exc_hit  = 1'b1;
            exc_code = EXC_RI;
        end else if (sys_i) begin
            exc_hit  = 1'b1;
            exc_code = EXC_SYS;
        end else if (bp_i) begin
            exc_hit  = 1'b1;
            exc_code = EXC_BP;
        end else if (ov_i) begin
            exc_hit  = 1'b1;
            exc_code = EXC_OV;
        end else if (adel_d_i) begin
            exc_hit       = 1'b1;
            exc_code      = EXC_ADEL;
            bad_from_addr = 1'b1;
        end else if (ades_i) begin
            exc_hit       = 1'b1;
            exc_code      = EXC_ADES;
            bad_from_addr = 1'b1;
        end
    end

    // A taken exception squashes the MEM-stage mtc0 along with the instruction.
    assign exc_take  = !rst && exc_valid_i && exc_hit;
    assign eret_take = !rst && exc_valid_i && eret_i && !exc_hit;
    assign wr_en     = we_i && !exc_take;

    assign flush_o   = exc_take || eret_take;
    assign newpc_o   = eret_take ? epc_q : EXC_VECTOR;
    assign exccode_o = exc_take ? exc_code : 5'd0;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = tick_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        timer_d   = timer_q;
        if (compare_q != 32'd0 && count_q == compare_q) begin
            timer_d = 1'b1;
        end
        if (wr_en && waddr_i == REG_COUNT) begin
            count_d = wdata_i;
        end
        if (wr_en && waddr_i == REG_COMPARE) begin
            compare_d = wdata_i;
            timer_d   = 1'b0;
        end
    end

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        cause_d[15:10] = {timer_q, int_i[4:0]};
        if (wr_en) begin
            case (waddr_i)
                REG_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                REG_CAUSE:  cause_d[9:8] = wdata_i[9:8];
                REG_EPC:    epc_d = wdata_i;
                default:    ;
            endcase
        end
        if (exc_take) begin
            // A nested exception keeps the EPC/BD of the one already being handled.
            if (!status_q[ST_EXL]) begin
                epc_d         = in_delayslot_i ? pc_i - 32'd4 : pc_i;
                cause_d[CA_BD] = in_delayslot_i;
            end
            status_d[ST_EXL] = 1'b1;
            cause_d[6:2]     = exc_code;
            if (bad_from_pc) begin
                badvaddr_d = pc_i;
            end else if (bad_from_addr) begin
                badvaddr_d = bad_addr_i;
            end
        end
        if (eret_take) begin
            status_d[ST_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            timer_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            timer_q    <= timer_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            REG_BADVADDR: rdata_o = badvaddr_q;
            REG_COUNT:    rdata_o = count_q;
            REG_COMPARE:  rdata_o = compare_q;
            REG_STATUS:   rdata_o = status_q;
            REG_CAUSE:    rdata_o = cause_q;
            REG_EPC:      rdata_o = epc_q;
            default:      rdata_o = 32'd0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign timer_int_o = timer_q;

endmodule
